// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and constants for the spike-rate decoder and its edge detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spike_pkg;

    // Default spike-count width for a result record.
    localparam int SPIKE_CNT_W = 8;

    // Number of flops in the optional spike_in synchroniser.
    localparam int SPIKE_SYNC_STAGES = 2;

    // Decoder control states.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } spike_state_e;

    // One window result at the default count width.
    typedef struct packed {
        logic                   sat;
        logic [SPIKE_CNT_W-1:0] count;
    } spike_result_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Bundle of the decoder's control, spike input and result valid/ready channel.
// Latency: n/a (wiring only).
// Backpressure: count_ready from the consumer stalls count_valid/count_out.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             spike_in;
    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             count_valid;
    logic             count_ready;
    logic             overrun;

    // Decoder side: consumes control/spikes, produces results.
    modport master (
        input  en,
        input  spike_in,
        input  count_ready,
        output count_out,
        output count_sat,
        output count_valid,
        output overrun
    );

    // Consumer side: drives control/spikes, accepts results.
    modport slave (
        output en,
        output spike_in,
        output count_ready,
        input  count_out,
        input  count_sat,
        input  count_valid,
        input  overrun
    );
endinterface

// File: rtl/spike_rate_decoder_edge_sync.sv
// Optional spike_in synchroniser followed by a rising-edge detector (macro SPIKE_DEC_SYNC_EN).
// Latency: edge_o is combinational from spike_i by default, 2 cycles later with SPIKE_DEC_SYNC_EN.
// Backpressure: none; emits a one-cycle pulse per rising edge.
module spike_edge_sync
    import spike_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic spike_i,
    output logic edge_o
);
    logic spk_s;
    logic spk_d_q;

`ifdef SPIKE_DEC_SYNC_EN
    logic [SPIKE_SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous spike train through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SPIKE_SYNC_STAGES-2:0], spike_i};
        end
    end

    assign spk_s = sync_q[SPIKE_SYNC_STAGES-1];
`else
    // Source is already synchronous to clk.
    assign spk_s = spike_i;
`endif

    // Delayed copy of the conditioned spike; resets low so a spike high out of reset counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_d_q <= 1'b0;
        end else begin
            spk_d_q <= spk_s;
        end
    end

    assign edge_o = spk_s & ~spk_d_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges over back-to-back WINDOW_CYCLES windows (sync option: SPIKE_DEC_SYNC_EN).
// Latency: result valid 1 cycle after the window's last cycle.
// Backpressure: result held until count_ready; a newer result overwrites an unaccepted one and flags overrun.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int WINDOW_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input logic                  clk,
    input logic                  rst,
    spike_rate_decoder_if.master bus
);
    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] count;
    } result_t;

    spike_state_e     state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
    logic             sat_q, sat_d;
    result_t          res_q, res_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             spk_edge;
    logic             spk_at_max;
    logic [CNT_W-1:0] spk_inc;
    logic             sat_hit;
    logic             load;
    logic             fire;

    spike_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .spike_i (bus.spike_in),
        .edge_o  (spk_edge)
    );

    // Window sequencing, saturating spike count and result/handshake next state.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        spk_cnt_d = spk_cnt_q;
        sat_d     = sat_q;
        res_d     = res_q;
        ovr_d     = ovr_q;
        load      = 1'b0;
        fire      = valid_q & bus.count_ready;

        spk_at_max = (spk_cnt_q == CNT_MAX);
        spk_inc    = (spk_edge && !spk_at_max) ? spk_cnt_q + 1'b1 : spk_cnt_q;
        sat_hit    = sat_q | (spk_edge & spk_at_max);

        case (state_q)
            IDLE: begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
                sat_d     = 1'b0;
                if (bus.en) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!bus.en) begin
                    // Partial window is dropped without a result.
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    sat_d     = 1'b0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // Last cycle: include this cycle's edge, restart with no gap.
                    load       = 1'b1;
                    res_d.count = spk_inc;
                    res_d.sat   = sat_hit;
                    win_cnt_d  = '0;
                    spk_cnt_d  = '0;
                    sat_d      = 1'b0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    spk_cnt_d = spk_inc;
                    sat_d     = sat_hit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = load | (valid_q & ~fire);

        if (load && valid_q && !bus.count_ready) begin
            ovr_d = 1'b1;
        end else if (fire) begin
            ovr_d = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            spk_cnt_q <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            spk_cnt_q <= spk_cnt_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.count_out   = res_q.count;
    assign bus.count_sat   = res_q.sat;
    assign bus.count_valid = valid_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Downstream consumer of the spikifier's digital spike output `q`. It counts rising edges of the spike train over fixed windows of WINDOW_CYCLES clocks, producing a spike-rate sample per window. Each sample is offered on a valid/ready interface to the digital back end. This is the first fully synchronous stage after the analog-to-spike front end.

Parameters:
WINDOW_CYCLES, 64, clock cycles per counting window (>=2)
CNT_W, 8, width of spike count; count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  enable counting; low = idle, partial window discarded
spike_in  input  1  spike train from spikifier q, asynchronous to clk
count_out  output  CNT_W  spike count of last completed window
count_sat  output  1  count_out saturated during that window
count_valid  output  1  result available
count_ready  input  1  consumer accepts result when valid & ready
overrun  output  1  an unconsumed result was overwritten; cleared on next accepted transfer

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: count_out=0, count_sat=0, count_valid=0, overrun=0, FSM=IDLE, window/spike counters=0.
- Edge detect: s = conditioned spike_in; s_d = s registered; edge = s & ~s_d. A spike held high N cycles counts once. s_d resets to 0, so a spike_in high out of reset counts as one edge.
- FSM IDLE: counters held at 0. Transitions to COUNT when en=1.
- FSM COUNT: win_cnt increments every cycle. spk_cnt increments on edge, saturating at 2^CNT_W-1; sat_flag is set if an edge arrives while spk_cnt is already at max.
- Window close, at win_cnt==WINDOW_CYCLES-1:
  - Result = spk_cnt + edge this cycle, saturating, plus sat flag.
  - Result loads into the output register; count_valid=1 on the next cycle.
  - win_cnt, spk_cnt and sat_flag clear; the next window starts on the next cycle with no gap.
- en=0 in COUNT: go to IDLE next cycle, discard the partial window, emit no result. A pending count_valid is kept until consumed.
- Handshake:
  - count_valid stays high and count_out/count_sat stay stable until valid & ready.
  - Accepted transfer: count_valid=0 next cycle unless a new result loads in the same cycle.
- Window close while valid=1 and ready=0: new result overwrites the old; count_valid stays 1; overrun=1 from the next cycle until the next accepted transfer.
- Window close while valid & ready in the same cycle: old result is transferred, new result loads, valid stays 1, no overrun.
- Latency: an edge at the conditioned signal is included in the window containing that cycle. The result is visible 1 cycle after the window's last cycle.
- Asynchronous rst mid-window: everything returns to reset values immediately; the partial window is lost.

Optional Feature:
SPIKE_DEC_SYNC_EN. When defined, spike_in passes through a 2-flop synchronizer (reset to 0) before edge detection, so an edge is recognised 2 cycles after the spike_in transition. When undefined, spike_in feeds edge detection directly with 0 added latency; a synchronous source is then required. All other behaviour is identical.

Decomposition:
- Package spike_pkg: FSM state enum (IDLE, COUNT); typedef spike_result_t struct {sat, count}, with count width from a localparam default; SPIKE_SYNC_STAGES=2 constant.
- Sub-module spike_edge_sync: optional synchronizer plus rising-edge detector; outputs a 1-cycle edge pulse. Reusable by other spike consumers.

Test Plan:
- WINDOW_CYCLES=16, CNT_W=8, ready=1: 5 single-cycle spikes spaced 3 cycles inside one window -> count_out=5, sat=0, valid high 1 cycle, 16 cycles after window start +1.
- Spike held high 10 consecutive cycles -> count_out=1. Spike rising on the last window cycle -> counted in that window. Spike rising on the first cycle of the next window -> counted there.
- WINDOW_CYCLES=64, CNT_W=4: 20 spikes (1 high, 1 low) -> count_out=15, count_sat=1. Following empty window -> 0, sat=0.
- ready=0 across two window closes with counts 3 then 7 -> count_out=7, overrun=1. Raise ready -> one transfer of 7, then valid=0 and overrun=0.
- en dropped at cycle 8 of a 16-cycle window after 4 spikes -> no result, FSM IDLE. en re-raised -> fresh window counts from 0.
- rst pulsed at cycle 5 while valid=1 -> all outputs 0 immediately. Repeat the first scenario with and without SPIKE_DEC_SYNC_EN -> same counts, edge timing shifted by 2 cycles.
